// File: rtl/spi_slave_phy.sv
// SPI slave bit engine, mode 0, MSB first, 8-bit frames.
// Pins are synchronised into clk; rx bytes and tx holding register are byte-level handshakes.
module spi_slave_phy #(
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       rxPacketStart,
    output logic [7:0] rxData,
    output logic       rxDataRdySet,
    input  logic [7:0] txData,
    input  logic       txDataFull,
    output logic       txDataEmpty,
    output logic       txDataFullClr,
    output logic       txUnderrun
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        rise_seen_q, rise_seen_d;
    logic        first_q, first_d;
    logic [6:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_start_q, rx_start_d;
    logic        byte_done_q, byte_done_d;
    logic        rdy_q, rdy_d;
    logic [6:0]  tx_sh_q, tx_sh_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        empty_q, empty_d;
    logic        clr_q, clr_d;
    logic        under_q, under_d;

    logic        tx_load;
    logic        tx_boundary;
    logic [7:0]  rx_byte;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign rx_byte  = {rx_sh_q, mosi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rise_seen_q <= 1'b0;
            first_q     <= 1'b0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_start_q  <= 1'b0;
            byte_done_q <= 1'b0;
            rdy_q       <= 1'b0;
            tx_sh_q     <= FILL_BYTE[6:0];
            miso_q      <= 1'b1;
            oe_q        <= 1'b0;
            empty_q     <= 1'b1;
            clr_q       <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rise_seen_q <= rise_seen_d;
            first_q     <= first_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_start_q  <= rx_start_d;
            byte_done_q <= byte_done_d;
            rdy_q       <= rdy_d;
            tx_sh_q     <= tx_sh_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            empty_q     <= empty_d;
            clr_q       <= clr_d;
            under_q     <= under_d;
        end
    end

    // Bit 7 of the tx shifter lives in miso_q; tx_sh_q holds the bits still to go.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rise_seen_d = rise_seen_q;
        first_d     = first_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_start_d  = rx_start_q;
        byte_done_d = 1'b0;
        rdy_d       = byte_done_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        empty_d     = empty_q;
        clr_d       = 1'b0;
        under_d     = under_q;
        tx_load     = 1'b0;
        tx_boundary = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    bit_cnt_d   = '0;
                    rise_seen_d = 1'b0;
                    first_d     = 1'b1;
                    under_d     = 1'b0;
                    oe_d        = 1'b1;
                    tx_load     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    oe_d      = 1'b0;
                    miso_d    = 1'b1;
                    empty_d   = 1'b1;
                end else if (sck_rise) begin
                    rx_sh_d     = rx_byte[6:0];
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    rise_seen_d = 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d   = rx_byte;
                        rx_start_d  = first_q;
                        first_d     = 1'b0;
                        byte_done_d = 1'b1;
                        empty_d     = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        miso_d  = tx_sh_q[6];
                        tx_sh_d = {tx_sh_q[5:0], 1'b1};
                    end else if (rise_seen_q) begin
                        tx_load     = 1'b1;
                        tx_boundary = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_load) begin
            if (txDataFull) begin
                miso_d  = txData[7];
                tx_sh_d = txData[6:0];
                clr_d   = 1'b1;
                empty_d = 1'b0;
            end else begin
                miso_d  = FILL_BYTE[7];
                tx_sh_d = FILL_BYTE[6:0];
                empty_d = 1'b1;
                if (tx_boundary) begin
                    under_d = 1'b1;
                end
            end
        end
    end

    assign spi_miso      = miso_q;
    assign spi_miso_oe   = oe_q;
    assign rxPacketStart = rx_start_q;
    assign rxData        = rx_data_q;
    assign rxDataRdySet  = rdy_q;
    assign txDataEmpty   = empty_q;
    assign txDataFullClr = clr_q;
    assign txUnderrun    = under_q;

endmodule
